// File: rtl/gh_pkg.sv
// Shared widths and position-word field offsets for the fret detector.
// Pure constants; no logic, no latency.
package gh_pkg;
    localparam int X_W       = 11;
    localparam int Y_W       = 10;
    localparam int CNT_W     = 5;
    localparam int POS_W     = 24;
    localparam int POS_X_LSB = 0;
    localparam int POS_Y_LSB = 12;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/gh_fret_window.sv
// One fret channel: lit-pixel count inside its window, hit decision and press state.
// Press updates on the clock after a decided frame edge; no backpressure. GH_FRET_FILTER_EN adds 2-frame debounce.
module gh_fret_window
    import gh_pkg::*;
#(
    parameter int WIN_W = 4,
    parameter int WIN_H = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [X_W-1:0]   xCnt,
    input  logic [Y_W-1:0]   yCnt,
    input  logic [X_W-1:0]   xPos,
    input  logic [Y_W-1:0]   yPos,
    input  logic             vde,
    input  logic             pixel,
    input  logic [CNT_W-1:0] hitThresh,
    input  logic             frameEdge,
    input  logic             decide,
    output logic             pressNext,
    output logic             press
);
    logic [X_W:0]     xEnd;
    logic [Y_W:0]     yEnd;
    logic             inWin;
    logic             hitNow;
    logic [CNT_W-1:0] litCnt;

    // One extra bit so windows near the counter limit truncate instead of wrapping
    assign xEnd = {1'b0, xPos} + (X_W+1)'(WIN_W - 1);
    assign yEnd = {1'b0, yPos} + (Y_W+1)'(WIN_H - 1);

    assign inWin = vde && pixel
                && (xCnt >= xPos) && ({1'b0, xCnt} <= xEnd)
                && (yCnt >= yPos) && ({1'b0, yCnt} <= yEnd);

    assign hitNow = (litCnt >= hitThresh);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            litCnt <= '0;
        else if (frameEdge)
            litCnt <= '0;
        else if (inWin && (litCnt != CNT_MAX))
            litCnt <= litCnt + CNT_W'(1);
    end

`ifdef GH_FRET_FILTER_EN
    logic hitPrev;

    always_comb begin
        pressNext = press;
        if (hitNow && hitPrev)
            pressNext = 1'b1;
        else if (!hitNow && !hitPrev)
            pressNext = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            hitPrev <= 1'b0;
        else if (decide)
            hitPrev <= hitNow;
    end
`else
    assign pressNext = hitNow;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            press <= 1'b0;
        else if (decide)
            press <= pressNext;
    end
endmodule

// File: rtl/gh_fret_array.sv
// Guitar fret/strum detector from thresholded video; optional GH_FRET_FILTER_EN debounce.
// Outputs move one cycle after the frame edge plus delay_in frames; no backpressure.
module gh_fret_array
    import gh_pkg::*;
#(
    parameter int NUM_FRETS   = 5,
    parameter int WIN_W       = 4,
    parameter int WIN_H       = 4,
    parameter int DELAY_DEPTH = 32,
    localparam int DW         = $clog2(DELAY_DEPTH)
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       enable,
    input  logic                       vsync,
    input  logic                       hsync,
    input  logic                       vde,
    input  logic                       pixel,
    input  logic [NUM_FRETS*POS_W-1:0] pos_in,
    input  logic [CNT_W-1:0]           hit_thresh,
    input  logic [DW-1:0]              delay_in,
    input  logic [3:0]                 strum_time,
    output logic [NUM_FRETS-1:0]       frets,
    output logic                       strum,
    output logic [NUM_FRETS-1:0]       frets_raw
);
    localparam int EW = NUM_FRETS + 1;

    logic [2:0]           vsSh, hsSh;
    logic                 frameEdge, lineEdge, decide, armed, lineHasDe;
    logic [X_W-1:0]       xCnt;
    logic [Y_W-1:0]       yCnt;
    logic [NUM_FRETS-1:0] pressNext, press;
    logic [3*NUM_FRETS-1:0] unusedPos;

    // Stages [0],[1] resynchronise; [2] holds the previous second stage for edge detect
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vsSh <= '0;
            hsSh <= '0;
        end else begin
            vsSh <= {vsSh[1:0], vsync};
            hsSh <= {hsSh[1:0], hsync};
        end
    end

    assign frameEdge = vsSh[1] & ~vsSh[2];
    assign lineEdge  = hsSh[1] & ~hsSh[2];
    // The first frame edge after reset only opens a frame; it never decides
    assign decide    = frameEdge & armed;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            xCnt      <= '0;
            yCnt      <= '0;
            lineHasDe <= 1'b0;
            armed     <= 1'b0;
        end else begin
            if (lineEdge)
                xCnt <= '0;
            else if (vde)
                xCnt <= xCnt + X_W'(1);
            if (frameEdge)
                yCnt <= '0;
            else if (lineEdge && lineHasDe)
                yCnt <= yCnt + Y_W'(1);
            if (frameEdge || lineEdge)
                lineHasDe <= 1'b0;
            else if (vde)
                lineHasDe <= 1'b1;
            if (frameEdge)
                armed <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_FRETS; i++) begin : gWin
        gh_fret_window #(
            .WIN_W(WIN_W),
            .WIN_H(WIN_H)
        ) uWin (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .xCnt     (xCnt),
            .yCnt     (yCnt),
            .xPos     (pos_in[i*POS_W+POS_X_LSB +: X_W]),
            .yPos     (pos_in[i*POS_W+POS_Y_LSB +: Y_W]),
            .vde      (vde),
            .pixel    (pixel),
            .hitThresh(hit_thresh),
            .frameEdge(frameEdge),
            .decide   (decide),
            .pressNext(pressNext[i]),
            .press    (press[i])
        );
        assign unusedPos[3*i +: 3] = {pos_in[i*POS_W+23 -: 2], pos_in[i*POS_W+11]};
    end

    logic       newPress, strumRaw, strumRawNext, restrum, restrumNext;
    logic [3:0] strumCnt, strumCntNext, strumLen;

    assign newPress = |(pressNext & ~press);
    assign strumLen = (strum_time == 4'd0) ? 4'd1 : strum_time;

    // A new press during an active strum drops it for one frame, then restarts it
    always_comb begin
        strumRawNext = strumRaw;
        strumCntNext = strumCnt;
        restrumNext  = restrum;
        if (newPress && strumRaw) begin
            strumRawNext = 1'b0;
            strumCntNext = 4'd0;
            restrumNext  = 1'b1;
        end else if (newPress || restrum) begin
            strumRawNext = 1'b1;
            strumCntNext = strumLen;
            restrumNext  = 1'b0;
        end else if (strumCnt > 4'd1) begin
            strumCntNext = strumCnt - 4'd1;
        end else begin
            strumRawNext = 1'b0;
            strumCntNext = 4'd0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            strumRaw <= 1'b0;
            strumCnt <= '0;
            restrum  <= 1'b0;
        end else if (decide) begin
            strumRaw <= strumRawNext;
            strumCnt <= strumCntNext;
            restrum  <= restrumNext;
        end
    end

    logic [EW-1:0]          dlyMem [DELAY_DEPTH];
    logic [DELAY_DEPTH-1:0] dlyVld;
    logic [DW-1:0]          wrPtr, rdPtr, dlySel;
    logic [EW-1:0]          dlyOut, selWord;

    assign rdPtr = wrPtr - delay_in;

    always_ff @(posedge CLK) begin
        if (decide)
            dlyMem[wrPtr] <= {strumRawNext, pressNext};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wrPtr  <= '0;
            dlyVld <= '0;
            dlyOut <= '0;
            dlySel <= '0;
        end else begin
            if (frameEdge)
                dlySel <= delay_in;
            if (decide) begin
                dlyVld[wrPtr] <= 1'b1;
                wrPtr         <= wrPtr + DW'(1);
                dlyOut        <= dlyVld[rdPtr] ? dlyMem[rdPtr] : '0;
            end
        end
    end

    assign selWord   = (dlySel == '0) ? {strumRaw, press} : dlyOut;
    assign frets     = enable ? selWord[NUM_FRETS-1:0] : '0;
    assign strum     = enable & selWord[NUM_FRETS];
    assign frets_raw = press;
endmodule

// File: doc/gh_fret_array.md
GH_FRET_ARRAY -- requirements
Module: gh_fret_array

Interface
REQ-001 Parameter NUM_FRETS, default 5, number of fret detection channels (1..8).
REQ-002 Parameter WIN_W, default 4, detection window width in pixels.
REQ-003 Parameter WIN_H, default 4, detection window height in lines.
REQ-004 Parameter DELAY_DEPTH, default 32, delay-line depth in frames (power of two); DW = log2(DELAY_DEPTH).
REQ-005 Port CLK in 1: pixel clock; the block SHALL use this single clock only.
REQ-006 Port RST_N in 1: reset, asynchronous and active-low.
REQ-007 Port enable in 1: output gate.
REQ-008 Port vsync, hsync in 1 each: raw sync levels.
REQ-009 Port vde in 1: active-video qualifier.
REQ-010 Port pixel in 1: thresholded pixel value.
REQ-011 Port pos_in in NUM_FRETS*24: per-channel word; channel i has x at [24i+10:24i], y at [24i+21:24i+12].
REQ-012 Port hit_thresh in 5: minimum lit-pixel count for a hit.
REQ-013 Port delay_in in DW: output delay in frames.
REQ-014 Port strum_time in 4: strum pulse length in frames.
REQ-015 Port frets out NUM_FRETS: delayed fret presses.
REQ-016 Port strum out 1: delayed strum.
REQ-017 Port frets_raw out NUM_FRETS: undelayed, ungated presses (status/LEDs).

Function
REQ-018 vsync and hsync SHALL each pass through a two-flop register; a frame edge (fe) or line edge (le) is a 0->1 transition of the second stage, one-cycle pulse.
REQ-019 11-bit x counter SHALL clear on le and increment on each cycle with vde=1; 10-bit y counter SHALL clear on fe and increment on le only if the finished line had at least one vde cycle.
REQ-020 Channel i SHALL count pixel=1 cycles with vde=1, x in [xi, xi+WIN_W-1], y in [yi, yi+WIN_H-1]; 5-bit counter saturating at 31.
REQ-021 On fe each channel SHALL latch hit = (count >= hit_thresh) and clear its counter in the same cycle; hit_thresh=0 SHALL always hit.
REQ-022 Window extending beyond the counter range SHALL simply truncate; no wrap of x or y.
REQ-023 Press state (frets_raw) SHALL update on fe per REQ-033/034.
REQ-024 Strum: on fe, if any fret of frets_raw rises 0->1 (new press), a strum counter SHALL load max(strum_time,1) and strum_raw=1 for that many frames.
REQ-025 New press while strum_raw=1 SHALL force strum_raw=0 for exactly one frame, then reload the counter (re-strum).
REQ-026 Delay line: DELAY_DEPTH x (NUM_FRETS+1) circular buffer, written with {strum_raw, frets_raw} on the fe after the update; write pointer increments mod DELAY_DEPTH.
REQ-027 delay_in=0 SHALL bypass the buffer; delay_in=d>0 SHALL output the entry written d frames earlier; entries unwritten since reset SHALL read as 0.
REQ-028 delay_in change SHALL take effect at the next fe.
REQ-029 frets/strum SHALL be zero when enable=0, combinationally; internal state SHALL keep running.
REQ-030 Latency: all outputs change one CLK cycle after the fe pulse (plus d frames).

Reset
REQ-031 RST_N=0 SHALL immediately clear sync flops, x/y, window counters, hits, press state, strum counter, write pointer and the buffer valid bits; all outputs read 0.
REQ-032 Reset mid-frame SHALL discard the partial frame; first decision occurs at the first complete fe after release.

Configuration
REQ-033 With GH_FRET_FILTER_EN defined, a press SHALL set only after hit on 2 consecutive frames and clear only after miss on 2 consecutive frames (one history bit per channel).
REQ-034 Without GH_FRET_FILTER_EN, press SHALL equal the latched hit of the current frame.

Structure
REQ-035 Package gh_pkg SHALL hold the 24-bit position field offsets, X_W=11, Y_W=10, and the counter width constant 5.
REQ-036 Per-channel window counter, hit and filter SHALL be sub-module gh_fret_window, instantiated NUM_FRETS times via generate.

Verification
REQ-037 Filter on, 4x4 lit block at channel 0 pos, hit_thresh=8, for 3 frames, delay_in=0 -> frets_raw[0] 0,1,1 at frames 1..3; strum high strum_time frames from frame 2.
REQ-038 Filter off, same stimulus, hit_thresh=17 -> frets_raw stays 0; hit_thresh=16 -> frets_raw[0]=1 at frame 1.
REQ-039 delay_in=5, single-frame press pattern -> frets/strum reproduce frets_raw/strum_raw exactly 5 frames later; first 5 frames after reset read 0.
REQ-040 Second fret pressed while strum active with strum_time=4 -> strum 1,0,1,1,1,1 across frames.
REQ-041 enable=0 during press -> frets=0, strum=0, frets_raw unaffected; re-enable mid-frame -> outputs valid next cycle.
REQ-042 RST_N asserted at line 100 of a pressed frame -> outputs 0 immediately; after release, no press until two full frames (filter on).
